// File: rtl/kv_lut_builder_if.sv
// kv_lut_builder_if: bundles the write, reverse-search and table-view signals
// of kv_lut_builder.
//   master : the user side. It drives wr_*, req_* and resp_ready, and it
//            observes the readies, the search result and the table view.
//   slave  : the table (kv_lut_builder). It takes the requests and drives
//            the readies, wr_err, resp_*, lut_out, count and full.
interface kv_lut_builder_if #(
  parameter int unsigned NR_KEY   = 4,
  parameter int unsigned KEY_LEN  = 3,
  parameter int unsigned DATA_LEN = 8
);
  localparam int unsigned PAIR_LEN = KEY_LEN + DATA_LEN;
  localparam int unsigned CNT_W    = $clog2(NR_KEY + 1);

  logic                       wr_valid;
  logic                       wr_ready;
  logic                       wr_del;
  logic [KEY_LEN-1:0]         wr_key;
  logic [DATA_LEN-1:0]        wr_data;
  logic                       wr_err;
  logic                       req_valid;
  logic                       req_ready;
  logic [DATA_LEN-1:0]        req_data;
  logic                       resp_valid;
  logic                       resp_ready;
  logic                       resp_hit;
  logic [KEY_LEN-1:0]         resp_key;
  logic [NR_KEY*PAIR_LEN-1:0] lut_out;
  logic [CNT_W-1:0]           count;
  logic                       full;

  modport master (
    output wr_valid, wr_del, wr_key, wr_data, req_valid, req_data, resp_ready,
    input  wr_ready, wr_err, req_ready, resp_valid, resp_hit, resp_key, lut_out, count, full
  );

  modport slave (
    input  wr_valid, wr_del, wr_key, wr_data, req_valid, req_data, resp_ready,
    output wr_ready, wr_err, req_ready, resp_valid, resp_hit, resp_key, lut_out, count, full
  );
endinterface

// File: rtl/kv_lut_builder.sv
// kv_lut_builder: register-based (key, data) table.
// It keeps a packed lookup list (lut_out) that feeds the key-select muxes.
// It also answers reverse data-to-key queries with a sequential scan.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : kv_lut_builder_if slave port, which carries:
//                - the write/delete request and wr_err,
//                - the search request and its response,
//                - lut_out, count and full.
module kv_lut_builder #(
  parameter int unsigned NR_KEY   = 4,
  parameter int unsigned KEY_LEN  = 3,
  parameter int unsigned DATA_LEN = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  kv_lut_builder_if.slave  bus
);
  localparam int unsigned PAIR_LEN = KEY_LEN + DATA_LEN;
  localparam int unsigned IDX_W    = $clog2(NR_KEY);
  localparam int unsigned CNT_W    = $clog2(NR_KEY + 1);

  typedef enum logic [1:0] {StIdle, StScan, StResp} state_e;

  state_e              state_q, state_d;
  logic [NR_KEY-1:0]   valid_q, valid_d;
  logic [KEY_LEN-1:0]  key_q  [NR_KEY];
  logic [KEY_LEN-1:0]  key_d  [NR_KEY];
  logic [DATA_LEN-1:0] data_q [NR_KEY];
  logic [DATA_LEN-1:0] data_d [NR_KEY];
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_LEN-1:0] sdata_q, sdata_d;
  logic                hit_q, hit_d;
  logic [KEY_LEN-1:0]  rkey_q, rkey_d;
  logic                err_q, err_d;

  logic                match_found, free_found;
  logic [IDX_W-1:0]    match_idx, free_idx;
  logic                wr_fire, scan_hit, scan_last;
  logic [CNT_W-1:0]    cnt;

  assign wr_fire   = bus.wr_valid && (state_q == StIdle);
  assign scan_hit  = valid_q[idx_q] && (data_q[idx_q] == sdata_q);
  assign scan_last = (idx_q == IDX_W'(NR_KEY - 1));

  // Lowest-index matching valid entry and lowest-index free entry.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int unsigned i = 0; i < NR_KEY; i++) begin
      if (!match_found && valid_q[i] && (key_q[i] == bus.wr_key)) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(i);
      end
      if (!free_found && !valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Table update. Writes are only accepted in idle, so a scan sees a frozen table.
  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    data_d  = data_q;
    err_d   = 1'b0;
    if (wr_fire) begin
      if (!bus.wr_del) begin
        if (match_found) begin
          data_d[match_idx] = bus.wr_data;
        end else if (free_found) begin
          valid_d[free_idx] = 1'b1;
          key_d[free_idx]   = bus.wr_key;
          data_d[free_idx]  = bus.wr_data;
        end else begin
          err_d = 1'b1;
        end
      end else if (match_found) begin
        valid_d[match_idx] = 1'b0;
        key_d[match_idx]   = '0;
        data_d[match_idx]  = '0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Reverse-search FSM.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sdata_d = sdata_q;
    hit_d   = hit_q;
    rkey_d  = rkey_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid && !bus.wr_valid) begin
          sdata_d = bus.req_data;
          idx_d   = '0;
          hit_d   = 1'b0;
          rkey_d  = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (scan_hit) begin
          hit_d   = 1'b1;
          rkey_d  = key_q[idx_q];
          state_d = StResp;
        end else if (scan_last) begin
          hit_d   = 1'b0;
          rkey_d  = '0;
          state_d = StResp;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      StResp: begin
        if (bus.resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      valid_q <= '0;
      for (int unsigned i = 0; i < NR_KEY; i++) begin
        key_q[i]  <= '0;
        data_q[i] <= '0;
      end
      idx_q   <= '0;
      sdata_q <= '0;
      hit_q   <= 1'b0;
      rkey_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      key_q   <= key_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      sdata_q <= sdata_d;
      hit_q   <= hit_d;
      rkey_q  <= rkey_d;
      err_q   <= err_d;
    end
  end

  // Occupancy count and packed table view. Invalid entries read as zero.
  always_comb begin
    cnt         = '0;
    bus.lut_out = '0;
    for (int unsigned i = 0; i < NR_KEY; i++) begin
      cnt = cnt + CNT_W'(valid_q[i]);
      if (valid_q[i]) bus.lut_out[PAIR_LEN*i +: PAIR_LEN] = {key_q[i], data_q[i]};
    end
  end

  assign bus.count      = cnt;
  assign bus.full       = (cnt == CNT_W'(NR_KEY));
  assign bus.wr_ready   = (state_q == StIdle);
  assign bus.req_ready  = (state_q == StIdle) && !bus.wr_valid;
  assign bus.wr_err     = err_q;
  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_hit   = hit_q;
  assign bus.resp_key   = rkey_q;
endmodule

// File: tb/tb_kv_lut_builder.sv
module tb_kv_lut_builder;
  localparam int NK = 4;
  localparam int KL = 3;
  localparam int DL = 8;
  localparam int PL = KL + DL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  kv_lut_builder_if #(.NR_KEY(NK), .KEY_LEN(KL), .DATA_LEN(DL)) bus ();

  kv_lut_builder #(.NR_KEY(NK), .KEY_LEN(KL), .DATA_LEN(DL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: the table as plain arrays.
  bit            mv [NK];
  logic [KL-1:0] mk [NK];
  logic [DL-1:0] md [NK];

  typedef struct {bit hit; logic [KL-1:0] key; int lat; int acc;} exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NK; i++) begin
      mv[i] = 1'b0; mk[i] = '0; md[i] = '0;
    end
  endtask

  task automatic model_write(input bit del, input logic [KL-1:0] k, input logic [DL-1:0] d,
                             output bit err);
    int m = -1;
    int f = -1;
    for (int i = 0; i < NK; i++) if (m < 0 && mv[i] && mk[i] == k) m = i;
    for (int i = 0; i < NK; i++) if (f < 0 && !mv[i]) f = i;
    err = 1'b0;
    if (!del) begin
      if (m >= 0) md[m] = d;
      else if (f >= 0) begin mv[f] = 1'b1; mk[f] = k; md[f] = d; end
      else err = 1'b1;
    end else begin
      if (m >= 0) begin mv[m] = 1'b0; mk[m] = '0; md[m] = '0; end
      else err = 1'b1;
    end
  endtask

  function automatic logic [NK*PL-1:0] model_lut();
    logic [NK*PL-1:0] r = '0;
    for (int i = 0; i < NK; i++) if (mv[i]) r[i*PL +: PL] = {mk[i], md[i]};
    return r;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < NK; i++) c += int'(mv[i]);
    return c;
  endfunction

  // A hit at entry i answers i+1 cycles after accept; a miss answers after NK cycles.
  task automatic push_exp(input logic [DL-1:0] d, input int acc);
    exp_t e;
    e.hit = 1'b0; e.key = '0; e.lat = NK; e.acc = acc;
    for (int i = NK - 1; i >= 0; i--)
      if (mv[i] && md[i] == d) begin e.hit = 1'b1; e.key = mk[i]; e.lat = i + 1; end
    exp_q.push_back(e);
  endtask

  task automatic chk_table(input string tag);
    chk({tag, "_lut"}, 64'(bus.lut_out), 64'(model_lut()));
    chk({tag, "_count"}, 64'(bus.count), 64'(model_count()));
    chk({tag, "_full"}, 64'(bus.full), 64'(model_count() == NK));
  endtask

  // Monitor: pops an expectation on each new response and checks that it holds stable.
  bit            in_resp = 1'b0;
  bit            held_hit;
  logic [KL-1:0] held_key;
  always @(negedge clk) begin
    if (rst_n && bus.resp_valid) begin
      if (!in_resp) begin
        exp_t e;
        in_resp = 1'b1;
        held_hit = bus.resp_hit;
        held_key = bus.resp_key;
        if (exp_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL unexpected_resp: got a response, required none (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("resp_hit", 64'(bus.resp_hit), 64'(e.hit));
          chk("resp_key", 64'(bus.resp_key), 64'(e.key));
          chk("resp_latency", 64'(cyc - e.acc), 64'(e.lat));
        end
      end else begin
        chk("resp_hit_stable", 64'(bus.resp_hit), 64'(held_hit));
        chk("resp_key_stable", 64'(bus.resp_key), 64'(held_key));
        chk("wr_ready_in_resp", 64'(bus.wr_ready), 64'd0);
      end
    end else begin
      in_resp = 1'b0;
    end
  end

  // All driving tasks start and end 1 time unit after a rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_del = 1'b0; bus.wr_key = '0; bus.wr_data = '0;
    bus.req_valid = 1'b0; bus.req_data = '0; bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_clear();
  endtask

  task automatic do_write(input bit del, input logic [KL-1:0] k, input logic [DL-1:0] d);
    bit e;
    bus.wr_valid = 1'b1; bus.wr_del = del; bus.wr_key = k; bus.wr_data = d;
    @(negedge clk);
    chk("wr_ready", 64'(bus.wr_ready), 64'd1);
    @(posedge clk);
    #1 bus.wr_valid = 1'b0;
    model_write(del, k, d, e);
    @(negedge clk);
    chk("wr_err", 64'(bus.wr_err), 64'(e));
    chk_table("wr");
    @(posedge clk);
    #1;
    if (e) begin
      @(negedge clk);
      chk("wr_err_pulse_end", 64'(bus.wr_err), 64'd0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic finish_search(input int hold);
    int  n = 0;
    bit  got = 1'b0;
    while (!got && n < NK + 4) begin
      @(negedge clk);
      if (bus.resp_valid) got = 1'b1;
      n++;
    end
    if (!got) begin
      n_checks++; n_err++;
      $display("FAIL resp_timeout: resp_valid=0 after %0d cycles, required 1", n);
    end
    repeat (hold) @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    @(negedge clk);
    chk("resp_valid_drop", 64'(bus.resp_valid), 64'd0);
    chk("wr_ready_after_resp", 64'(bus.wr_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_search(input logic [DL-1:0] d, input int hold);
    bus.req_valid = 1'b1; bus.req_data = d;
    @(negedge clk);
    chk("req_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    push_exp(d, cyc);
    finish_search(hold);
  endtask

  initial begin
    bit dummy;
    do_reset();
    @(negedge clk);
    chk("rst_lut", 64'(bus.lut_out), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_wr_err", 64'(bus.wr_err), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_hit", 64'(bus.resp_hit), 64'd0);
    chk("rst_resp_key", 64'(bus.resp_key), 64'd0);
    chk("rst_wr_ready", 64'(bus.wr_ready), 64'd1);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;

    // Single insert lands in entry 0.
    do_write(1'b0, 3'd3, 8'h5A);
    chk("t1_entry0", 64'(bus.lut_out[PL-1:0]), 64'h35A);

    // Fill the table, then overflow it.
    do_reset();
    for (int k = 0; k < NK; k++) do_write(1'b0, KL'(k), DL'(8'h10 + k));
    do_write(1'b0, 3'd5, 8'h99);

    // Update in place, then hit at entry 1 and miss with a held response.
    do_write(1'b0, 3'd1, 8'hFF);
    do_search(8'hFF, 0);
    do_search(8'h77, 3);

    // A write and a search in the same cycle: the write wins.
    bus.wr_valid = 1'b1; bus.wr_del = 1'b1; bus.wr_key = 3'd2;
    bus.req_valid = 1'b1; bus.req_data = 8'h13;
    @(negedge clk);
    chk("t5_req_ready_blocked", 64'(bus.req_ready), 64'd0);
    chk("t5_wr_ready", 64'(bus.wr_ready), 64'd1);
    @(posedge clk);
    #1 bus.wr_valid = 1'b0;
    model_write(1'b1, 3'd2, 8'h00, dummy);
    @(negedge clk);
    chk_table("t5");
    chk("t5_req_ready_next", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    push_exp(8'h13, cyc);
    finish_search(1);

    // Delete miss, and a search of data value 0.
    do_write(1'b1, 3'd6, 8'h00);
    do_write(1'b0, 3'd7, 8'h00);
    do_search(8'h00, 0);

    // Reset during a scan.
    bus.req_valid = 1'b1; bus.req_data = 8'h13;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    chk("t6_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("t6_lut", 64'(bus.lut_out), 64'd0);
    chk("t6_count", 64'(bus.count), 64'd0);
    chk("t6_wr_ready", 64'(bus.wr_ready), 64'd1);
    @(posedge clk);
    #1;

    // Random mix of inserts, deletes and searches over a small key/data space.
    for (int it = 0; it < 200; it++) begin
      int r = int'($urandom_range(0, 9));
      if (r < 4) do_write(1'b0, KL'($urandom_range(0, 7)), DL'($urandom_range(0, 3) * 17));
      else if (r < 6) do_write(1'b1, KL'($urandom_range(0, 7)), DL'($urandom));
      else do_search(DL'($urandom_range(0, 4) * 17), int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    chk("pending_responses", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/kv_lut_builder.md
Name: kv_lut_builder

Overview:
- Register-based (key, data) table that writes and maintains the packed lookup list consumed by the team's key-select muxes.
- Also services the reverse direction: given a data value, it scans the table sequentially and returns the matching key.
- Sits beside decode/CSR logic: writers populate entries, `lut_out` feeds a key-select mux directly, and the reverse-search port answers data-to-key queries.

Parameters:
- NR_KEY, 4, number of table entries; must be >= 2.
- KEY_LEN, 3, key width in bits.
- DATA_LEN, 8, data width in bits.
- Derived (localparam, not overridable):
  - PAIR_LEN = KEY_LEN+DATA_LEN.
  - IDX_W = $clog2(NR_KEY).
  - CNT_W = $clog2(NR_KEY+1).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- wr_valid  in  1  write/delete request valid.
- wr_ready  out  1  table accepts a write this cycle.
- wr_del  in  1  1 = delete entry with wr_key; 0 = insert/update.
- wr_key  in  KEY_LEN  key to write or delete.
- wr_data  in  DATA_LEN  data to write (ignored on delete).
- wr_err  out  1  one-cycle pulse: insert dropped (table full), or delete missed.
- req_valid  in  1  reverse-search request valid.
- req_ready  out  1  search accepted this cycle.
- req_data  in  DATA_LEN  data value to search for.
- resp_valid  out  1  search result valid.
- resp_ready  in  1  consumer takes the result.
- resp_hit  out  1  1 = match found.
- resp_key  out  KEY_LEN  matching key; 0 on miss.
- lut_out  out  NR_KEY*PAIR_LEN  packed table:
  - Entry n occupies [PAIR_LEN*(n+1)-1 : PAIR_LEN*n].
  - Key is in the upper KEY_LEN bits, data in the lower DATA_LEN bits.
  - Invalid entries drive all-zero.
- count  out  CNT_W  number of valid entries.
- full  out  1  count == NR_KEY.

Behaviour:
- Reset (rst_n=0 at an edge, in any state, including mid-scan or in RESP):
  - All entry valid bits, keys and data cleared; FSM -> IDLE.
  - Outputs after reset: lut_out=0, count=0, full=0, wr_err=0, resp_valid=0, resp_hit=0, resp_key=0, wr_ready=1, req_ready=1 (the latter only while req_valid-side conditions hold, see below).
- Any pending search is discarded on reset.
- FSM states: IDLE, SCAN, RESP.
- wr_ready = (state==IDLE).
- req_ready = (state==IDLE) && !wr_valid. A write always wins over a search in the same cycle.
- Write (fires on wr_valid && wr_ready); effect is visible on lut_out/count the next cycle. Decision order:
  - Insert, key matches a valid entry -> overwrite that entry's data in place (lowest index if duplicates); count unchanged.
  - Insert, no match, table not full -> allocate the lowest-index invalid entry; count+1.
  - Insert, no match, table full -> table unchanged; wr_err=1 for exactly one cycle.
  - Delete, match -> clear the lowest matching entry (valid=0, key=0, data=0); count-1.
  - Delete, no match -> table unchanged; wr_err=1 for one cycle.
- Search accept (req_valid && req_ready at edge E0):
  - Latch req_data; idx=0; -> SCAN.
- SCAN, one entry per cycle:
  - Entry idx valid and data==latched value -> resp_hit=1, resp_key=key[idx], -> RESP.
  - Otherwise, if idx==NR_KEY-1 -> resp_hit=0, resp_key=0, -> RESP.
  - Otherwise idx+1.
- Search latency:
  - Hit at entry i: resp_valid rises after edge E(i+1).
  - Miss: resp_valid rises after edge E(NR_KEY).
- RESP:
  - resp_valid=1; resp_hit and resp_key are held stable until resp_ready.
  - On resp_valid && resp_ready: resp_valid=0 at that edge, -> IDLE. The next request can be accepted the cycle after.
- The table is frozen in SCAN and RESP (wr_ready=0), so a search sees a consistent snapshot.
- Data value 0 is searchable; only valid entries can match.
- count never exceeds NR_KEY and never underflows.

Test Plan:
1. Reset, then insert (k=3,d=0x5A) -> next cycle lut_out[10:0]={3'd3,8'h5A}, count=1, full=0, wr_err=0.
2. Insert keys 0,1,2,3 (d=0x10..0x13), then insert k=5 -> full=1, count=4; k=5 insert pulses wr_err=1 for one cycle; lut_out unchanged.
3. Update k=1 to d=0xFF, then search 0xFF -> resp_hit=1, resp_key=1, resp_valid high 2 cycles after accept; count stays 4.
4. Search 0x77 (absent), NR_KEY=4 -> resp_hit=0, resp_key=0, resp_valid 4 cycles after accept. Hold resp_ready=0 for 3 cycles -> result stays stable; wr_ready=0 throughout.
5. Assert wr_valid (delete k=2) and req_valid together in IDLE -> delete fires, req_ready=0. Entry 2 zeroed, count=3. Search accepted next cycle.
6. Assert rst_n=0 while in SCAN -> next cycle state IDLE, resp_valid=0, lut_out=0, count=0, and wr_ready=1.
